// File: rtl/fetch_unit_pkg.sv
// Shared constants and the fetch queue entry type for the fetch stage.
// FETCH_MISALIGN_CHECK_EN adds a misalign marker bit to each queue entry.
`ifndef FETCH_UNIT_DEFINES
`define FETCH_UNIT_DEFINES
`define NOP_INST      32'h0000_0013
`define INST_BUS      31:0
`define INST_ADDR_BUS 31:0
`define RST_ENABLE    1'b1
`define ZERO_WORD     32'h0000_0000
`endif

package fetch_unit_pkg;

  localparam logic [31:0] NopInst  = `NOP_INST;
  localparam logic [31:0] ZeroWord = `ZERO_WORD;

  typedef struct packed {
    logic [`INST_ADDR_BUS] pc;
    logic [`INST_BUS]      inst;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic                  misalign;
`endif
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// ROM read port, redirect input and decode handshake of the fetch stage.
// FETCH_MISALIGN_CHECK_EN adds id_misalign_o.
interface fetch_unit_if;
  logic                  rom_ena_o;
  logic [`INST_ADDR_BUS] rom_addr_o;
  logic [`INST_BUS]      rom_data_i;
  logic                  redirect_i;
  logic [`INST_ADDR_BUS] redirect_pc_i;
  logic                  id_ready_i;
  logic                  id_valid_o;
  logic [`INST_BUS]      id_inst_o;
  logic [`INST_ADDR_BUS] id_pc_o;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic                  id_misalign_o;
`endif

  modport master (
    input  rom_data_i, redirect_i, redirect_pc_i, id_ready_i,
`ifdef FETCH_MISALIGN_CHECK_EN
    output id_misalign_o,
`endif
    output rom_ena_o, rom_addr_o, id_valid_o, id_inst_o, id_pc_o
  );

  modport slave (
    output rom_data_i, redirect_i, redirect_pc_i, id_ready_i,
`ifdef FETCH_MISALIGN_CHECK_EN
    input  id_misalign_o,
`endif
    input  rom_ena_o, rom_addr_o, id_valid_o, id_inst_o, id_pc_o
  );
endinterface

// File: rtl/fetch_queue.sv
// In-order FIFO of fetched {pc, inst} entries with synchronous flush.
// Head is read from registered storage and forced to zero when empty.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  fetch_entry_t               push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output fetch_entry_t               head_o,
  output logic                       head_valid_o,
  output logic [$clog2(Depth):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] rptr_q, wptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  always_comb begin
    empty_o      = (count_q == '0);
    full_o       = (count_q == CntW'(Depth));
    head_valid_o = !empty_o;
    head_o       = empty_o ? '0 : mem_q[rptr_q];
    count_o      = count_q;
    do_push      = push_i && (!full_o || pop_i);
    do_pop       = pop_i && !empty_o;
  end

  // Flush discards every entry, including any push/pop requested alongside it.
  always_ff @(posedge clk) begin
    if (rst == `RST_ENABLE || flush_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= push_data_i;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, ROM fetch control and redirect handling.
// FETCH_MISALIGN_CHECK_EN enables the misaligned-target marker and halt.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus_io
);

  logic [31:0]              pc_q, pc_d, target;
  logic                     rst_act, fetch, pop, push, halt;
  logic                     head_valid, full, empty;
  logic [$clog2(QUEUE_DEPTH):0] count;
  fetch_entry_t             push_data, head;
  logic                     unused_q_status;

  assign unused_q_status = ^{count, empty};
  assign rst_act         = (rst == `RST_ENABLE);

`ifdef FETCH_MISALIGN_CHECK_EN
  logic halt_q, pend_q, misaligned;
  assign misaligned = (bus_io.redirect_pc_i[1:0] != 2'b00);
  assign halt       = halt_q;
  assign target     = misaligned ? bus_io.redirect_pc_i : {bus_io.redirect_pc_i[31:2], 2'b00};
`else
  logic unused_rpc_low;
  assign unused_rpc_low = ^bus_io.redirect_pc_i[1:0];
  assign halt           = 1'b0;
  assign target         = {bus_io.redirect_pc_i[31:2], 2'b00};
`endif

  always_comb begin
    pop            = head_valid && bus_io.id_ready_i;
    fetch          = !rst_act && !bus_io.redirect_i && !halt && (!full || pop);
    push           = fetch;
    push_data      = '0;
    push_data.pc   = pc_q;
    push_data.inst = bus_io.rom_data_i;
`ifdef FETCH_MISALIGN_CHECK_EN
    // Marker entry for a misaligned redirect goes in the cycle after it.
    if (pend_q && !rst_act && !bus_io.redirect_i && (!full || pop)) begin
      push               = 1'b1;
      push_data.inst     = NopInst;
      push_data.misalign = 1'b1;
    end
`endif
    pc_d = pc_q;
    if (bus_io.redirect_i) begin
      pc_d = target;
    end else if (fetch) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == `RST_ENABLE) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst == `RST_ENABLE) begin
      halt_q <= 1'b0;
      pend_q <= 1'b0;
    end else if (bus_io.redirect_i) begin
      halt_q <= misaligned;
      pend_q <= misaligned;
    end else begin
      pend_q <= 1'b0;
    end
  end

  assign bus_io.id_misalign_o = head.misalign;
`endif

  fetch_queue #(
    .Depth (QUEUE_DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_data_i  (push_data),
    .pop_i        (pop),
    .flush_i      (bus_io.redirect_i),
    .head_o       (head),
    .head_valid_o (head_valid),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (empty)
  );

  assign bus_io.rom_ena_o  = fetch;
  assign bus_io.rom_addr_o = rst_act ? RESET_PC : pc_q;
  assign bus_io.id_valid_o = head_valid;
  assign bus_io.id_inst_o  = head.inst;
  assign bus_io.id_pc_o    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; run with and without FETCH_MISALIGN_CHECK_EN.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fetch_unit_if b0 ();
  fetch_unit_if b1 ();

  // ROM word i holds 32'h1000_0000 + i
  assign b0.rom_data_i = 32'h1000_0000 + {2'b00, b0.rom_addr_o[31:2]};
  assign b1.rom_data_i = 32'h1000_0000 + {2'b00, b1.rom_addr_o[31:2]};

  fetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2)) dut0 (
    .clk    (clk),
    .rst    (rst0),
    .bus_io (b0)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(2)) dut1 (
    .clk    (clk),
    .rst    (rst1),
    .bus_io (b1)
  );

  task automatic do_reset(input logic ready);
    rst0 = 1'b1;
    b0.redirect_i = 1'b0;
    @(posedge clk); #1;
    rst0 = 1'b0;
    b0.id_ready_i = ready;
    #1;
  endtask

  task automatic test_reset();
    b0.id_ready_i = 1'b1; b0.redirect_i = 1'b0; b0.redirect_pc_i = '0;
    b1.id_ready_i = 1'b1; b1.redirect_i = 1'b0; b1.redirect_pc_i = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (b0.id_valid_o !== 1'b0) begin n_fail++;
      $display("FAIL reset_valid: got %b want 0", b0.id_valid_o); end
    n_cmp++; if (b0.id_inst_o !== 32'h0) begin n_fail++;
      $display("FAIL reset_inst: got %h want 0", b0.id_inst_o); end
    n_cmp++; if (b0.id_pc_o !== 32'h0) begin n_fail++;
      $display("FAIL reset_pc: got %h want 0", b0.id_pc_o); end
    n_cmp++; if (b0.rom_ena_o !== 1'b0) begin n_fail++;
      $display("FAIL reset_rom_ena: got %b want 0", b0.rom_ena_o); end
    n_cmp++; if (b1.rom_addr_o !== 32'hFFFF_FFF8) begin n_fail++;
      $display("FAIL reset_rom_addr: got %h want fffffff8", b1.rom_addr_o); end
    n_cmp++; if (b1.rom_ena_o !== 1'b0) begin n_fail++;
      $display("FAIL reset_rom_ena1: got %b want 0", b1.rom_ena_o); end
`ifdef FETCH_MISALIGN_CHECK_EN
    n_cmp++; if (b0.id_misalign_o !== 1'b0) begin n_fail++;
      $display("FAIL reset_misalign: got %b want 0", b0.id_misalign_o); end
`endif
  endtask

  task automatic test_stream();
    logic [31:0] ep, ei, ea;
    @(posedge clk); #1;
    rst0 = 1'b0; b0.id_ready_i = 1'b1;
    #1;
    n_cmp++; if (b0.rom_ena_o !== 1'b1 || b0.rom_addr_o !== 32'h0) begin n_fail++;
      $display("FAIL stream_t0: got ena=%b addr=%h want 1/0", b0.rom_ena_o, b0.rom_addr_o); end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      ep = 32'(4 * i); ei = 32'h1000_0000 + 32'(i); ea = 32'(4 * (i + 1));
      n_cmp++; if (b0.id_valid_o !== 1'b1) begin n_fail++;
        $display("FAIL stream_valid[%0d]: got %b want 1", i, b0.id_valid_o); end
      n_cmp++; if (b0.id_pc_o !== ep) begin n_fail++;
        $display("FAIL stream_pc[%0d]: got %h want %h", i, b0.id_pc_o, ep); end
      n_cmp++; if (b0.id_inst_o !== ei) begin n_fail++;
        $display("FAIL stream_inst[%0d]: got %h want %h", i, b0.id_inst_o, ei); end
      n_cmp++; if (b0.rom_ena_o !== 1'b1 || b0.rom_addr_o !== ea) begin n_fail++;
        $display("FAIL stream_fetch[%0d]: got %b/%h want 1/%h", i, b0.rom_ena_o,
                 b0.rom_addr_o, ea); end
    end
  endtask

  task automatic test_stall();
    int fetches = 0;
    logic [31:0] ep;
    do_reset(1'b0);
    for (int c = 0; c < 6; c++) begin
      if (b0.rom_ena_o === 1'b1) fetches++;
      @(posedge clk); #1;
    end
    n_cmp++; if (fetches !== 2) begin n_fail++;
      $display("FAIL stall_fetches: got %0d want 2", fetches); end
    n_cmp++; if (b0.rom_ena_o !== 1'b0 || b0.rom_addr_o !== 32'h8) begin n_fail++;
      $display("FAIL stall_frozen: got %b/%h want 0/8", b0.rom_ena_o, b0.rom_addr_o); end
    n_cmp++; if (b0.id_valid_o !== 1'b1 || b0.id_pc_o !== 32'h0) begin n_fail++;
      $display("FAIL stall_head: got %b/%h want 1/0", b0.id_valid_o, b0.id_pc_o); end
    b0.id_ready_i = 1'b1;
    #1;
    n_cmp++; if (b0.rom_ena_o !== 1'b1 || b0.rom_addr_o !== 32'h8) begin n_fail++;
      $display("FAIL stall_resume: got %b/%h want 1/8", b0.rom_ena_o, b0.rom_addr_o); end
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      ep = 32'(4 * k);
      n_cmp++; if (b0.id_pc_o !== ep || b0.id_inst_o !== 32'h1000_0000 + 32'(k)) begin
        n_fail++;
        $display("FAIL stall_seq[%0d]: got %h/%h want %h/%h", k, b0.id_pc_o, b0.id_inst_o,
                 ep, 32'h1000_0000 + 32'(k)); end
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    repeat (2) begin @(posedge clk); #1; end
    n_cmp++; if (b0.rom_ena_o !== 1'b0) begin n_fail++;
      $display("FAIL redir_full: got %b want 0", b0.rom_ena_o); end
    b0.id_ready_i = 1'b1; b0.redirect_i = 1'b1; b0.redirect_pc_i = 32'h0000_0100;
    #1;
    n_cmp++; if (b0.id_valid_o !== 1'b1 || b0.id_pc_o !== 32'h0 || b0.rom_ena_o !== 1'b0)
    begin n_fail++;
      $display("FAIL redir_pop: got v=%b pc=%h ena=%b want 1/0/0", b0.id_valid_o, b0.id_pc_o,
               b0.rom_ena_o); end
    @(posedge clk); #1;
    b0.redirect_i = 1'b0;
    #1;
    n_cmp++; if (b0.id_valid_o !== 1'b0) begin n_fail++;
      $display("FAIL redir_bubble: got %b want 0", b0.id_valid_o); end
    n_cmp++; if (b0.rom_ena_o !== 1'b1 || b0.rom_addr_o !== 32'h100) begin n_fail++;
      $display("FAIL redir_fetch: got %b/%h want 1/100", b0.rom_ena_o, b0.rom_addr_o); end
    @(posedge clk); #1;
    n_cmp++; if (b0.id_valid_o !== 1'b1 || b0.id_pc_o !== 32'h100 ||
                 b0.id_inst_o !== 32'h1000_0040) begin n_fail++;
      $display("FAIL redir_head: got %b/%h/%h want 1/100/10000040", b0.id_valid_o,
               b0.id_pc_o, b0.id_inst_o); end
    @(posedge clk); #1;
    n_cmp++; if (b0.id_pc_o !== 32'h104) begin n_fail++;
      $display("FAIL redir_next: got %h want 104", b0.id_pc_o); end
`ifndef FETCH_MISALIGN_CHECK_EN
    b0.redirect_i = 1'b1; b0.redirect_pc_i = 32'h0000_0106;
    @(posedge clk); #1;
    b0.redirect_i = 1'b0;
    #1;
    n_cmp++; if (b0.rom_addr_o !== 32'h104) begin n_fail++;
      $display("FAIL redir_align: got %h want 104", b0.rom_addr_o); end
    @(posedge clk); #1;
    n_cmp++; if (b0.id_pc_o !== 32'h104 || b0.id_valid_o !== 1'b1) begin n_fail++;
      $display("FAIL redir_align_head: got %b/%h want 1/104", b0.id_valid_o, b0.id_pc_o); end
`endif
  endtask

  task automatic test_wrap();
    logic [31:0] ep, ei;
    @(posedge clk); #1;
    rst1 = 1'b0;
    #1;
    n_cmp++; if (b1.rom_ena_o !== 1'b1 || b1.rom_addr_o !== 32'hFFFF_FFF8) begin n_fail++;
      $display("FAIL wrap_t0: got %b/%h want 1/fffffff8", b1.rom_ena_o, b1.rom_addr_o); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      case (i)
        0:       begin ep = 32'hFFFF_FFF8; ei = 32'h4FFF_FFFE; end
        1:       begin ep = 32'hFFFF_FFFC; ei = 32'h4FFF_FFFF; end
        default: begin ep = 32'h0000_0000; ei = 32'h1000_0000; end
      endcase
      n_cmp++; if (b1.id_valid_o !== 1'b1 || b1.id_pc_o !== ep || b1.id_inst_o !== ei) begin
        n_fail++;
        $display("FAIL wrap_head[%0d]: got %b/%h/%h want 1/%h/%h", i, b1.id_valid_o,
                 b1.id_pc_o, b1.id_inst_o, ep, ei); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1);
    repeat (3) begin @(posedge clk); #1; end
    rst0 = 1'b1; b0.redirect_i = 1'b1; b0.redirect_pc_i = 32'h0000_0300;
    #1;
    n_cmp++; if (b0.rom_ena_o !== 1'b0 || b0.rom_addr_o !== 32'h0) begin n_fail++;
      $display("FAIL rstmid_rom: got %b/%h want 0/0", b0.rom_ena_o, b0.rom_addr_o); end
    @(posedge clk); #1;
    rst0 = 1'b0; b0.redirect_i = 1'b0;
    #1;
    n_cmp++; if (b0.id_valid_o !== 1'b0) begin n_fail++;
      $display("FAIL rstmid_empty: got %b want 0", b0.id_valid_o); end
    n_cmp++; if (b0.rom_ena_o !== 1'b1 || b0.rom_addr_o !== 32'h0) begin n_fail++;
      $display("FAIL rstmid_restart: got %b/%h want 1/0", b0.rom_ena_o, b0.rom_addr_o); end
    @(posedge clk); #1;
    n_cmp++; if (b0.id_valid_o !== 1'b1 || b0.id_pc_o !== 32'h0 ||
                 b0.id_inst_o !== 32'h1000_0000) begin n_fail++;
      $display("FAIL rstmid_head: got %b/%h/%h want 1/0/10000000", b0.id_valid_o,
               b0.id_pc_o, b0.id_inst_o); end
  endtask

`ifdef FETCH_MISALIGN_CHECK_EN
  task automatic test_misalign();
    int stray = 0;
    do_reset(1'b1);
    b0.redirect_i = 1'b1; b0.redirect_pc_i = 32'h0000_0102;
    @(posedge clk); #1;
    b0.redirect_i = 1'b0;
    #1;
    n_cmp++; if (b0.id_valid_o !== 1'b0 || b0.rom_ena_o !== 1'b0) begin n_fail++;
      $display("FAIL mis_bubble: got %b/%b want 0/0", b0.id_valid_o, b0.rom_ena_o); end
    @(posedge clk); #1;
    n_cmp++; if (b0.id_valid_o !== 1'b1 || b0.id_pc_o !== 32'h102 ||
                 b0.id_inst_o !== 32'h0000_0013 || b0.id_misalign_o !== 1'b1) begin n_fail++;
      $display("FAIL mis_marker: got %b/%h/%h/%b want 1/102/13/1", b0.id_valid_o,
               b0.id_pc_o, b0.id_inst_o, b0.id_misalign_o); end
    for (int c = 0; c < 4; c++) begin
      if (b0.rom_ena_o !== 1'b0) stray++;
      @(posedge clk); #1;
      if (b0.id_valid_o !== 1'b0) stray++;
    end
    n_cmp++; if (stray !== 0) begin n_fail++;
      $display("FAIL mis_halt: got %0d stray cycles want 0", stray); end
    b0.redirect_i = 1'b1; b0.redirect_pc_i = 32'h0000_0200;
    @(posedge clk); #1;
    b0.redirect_i = 1'b0;
    #1;
    n_cmp++; if (b0.rom_ena_o !== 1'b1 || b0.rom_addr_o !== 32'h200) begin n_fail++;
      $display("FAIL mis_resume: got %b/%h want 1/200", b0.rom_ena_o, b0.rom_addr_o); end
    @(posedge clk); #1;
    n_cmp++; if (b0.id_valid_o !== 1'b1 || b0.id_pc_o !== 32'h200 ||
                 b0.id_misalign_o !== 1'b0) begin n_fail++;
      $display("FAIL mis_head: got %b/%h/%b want 1/200/0", b0.id_valid_o, b0.id_pc_o,
               b0.id_misalign_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid();
`ifdef FETCH_MISALIGN_CHECK_EN
    test_misalign();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
